// File: rtl/seq_det_pkg.sv
// Shared defaults and sizing helper for the serial pattern detector.
package seq_det_pkg;

   localparam int SEQ_LEN_DEFAULT = 4;
   localparam logic [3:0] SEQ_PAT_DEFAULT = 4'b1101;

   // Fill counter must reach PAT_LEN itself, hence the +1.
   function automatic int cnt_width(input int pat_len);
      return $clog2(pat_len + 1);
   endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// History shift register with saturating fill counter; next-state values exposed.
// Zero added latency: hist_nxt_o/full_nxt_o are combinational views of the coming edge.
module seq_shift_reg
   import seq_det_pkg::*;
#(
   parameter int W = SEQ_LEN_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         bit_i,
   input  logic         clr_i,
   output logic [W-1:0] hist_nxt_o,
   output logic         full_nxt_o
);

   localparam int CW = cnt_width(W);
   localparam logic [CW-1:0] FULL = CW'(W);

   logic [W-1:0]  hist_q, hist_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      hist_d = {hist_q[W-2:0], bit_i};
      cnt_d  = (cnt_q == FULL) ? cnt_q : cnt_q + 1'b1;
   end

   assign hist_nxt_o = hist_d;
   assign full_nxt_o = (cnt_d == FULL);

   // A clear overrides the shift so history restarts empty after a non-overlapping match.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist_q <= '0;
         cnt_q  <= '0;
      end else if (clr_i) begin
         hist_q <= '0;
         cnt_q  <= '0;
      end else begin
         hist_q <= hist_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/seq_detector.sv
// Serial bit-pattern detector: one bit per clock, one-cycle registered pulse per match.
// Pulse appears the cycle after the final pattern bit is sampled; no backpressure.
module seq_detector
   import seq_det_pkg::*;
#(
   parameter int PAT_LEN = SEQ_LEN_DEFAULT,
   parameter     PATTERN = SEQ_PAT_DEFAULT,
   parameter bit OVERLAP = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic out
);

   if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_len
      $error("seq_detector: PAT_LEN %0d outside 2..16", PAT_LEN);
   end
   if ($bits(PATTERN) != PAT_LEN) begin : g_bad_pat
      $error("seq_detector: PATTERN width %0d differs from PAT_LEN %0d", $bits(PATTERN), PAT_LEN);
   end

   localparam logic [PAT_LEN-1:0] PAT = PAT_LEN'(PATTERN);

   logic [PAT_LEN-1:0] hist_nxt;
   logic               full_nxt;
   logic               match_d;
   logic               out_q;

   // Requiring a full window keeps reset-zero history from matching all-zero patterns.
   assign match_d = full_nxt && (hist_nxt == PAT);

   seq_shift_reg #(
      .W (PAT_LEN)
   ) u_shift (
      .clk        (clk),
      .rst        (rst),
      .bit_i      (in),
      .clr_i      (match_d && !OVERLAP),
      .hist_nxt_o (hist_nxt),
      .full_nxt_o (full_nxt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q <= 1'b0;
      end else begin
         out_q <= match_d;
      end
   end

   assign out = out_q;

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench: four detector variants share one stream; expectations are hand-computed.
module tb_seq_detector;

   logic clk;
   logic rst;
   logic din;
   logic out_def, out_nov, out_z1, out_z0;
   int   checks;
   int   errors;

   seq_detector u_def (.clk(clk), .rst(rst), .in(din), .out(out_def));
   seq_detector #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b0))
      u_nov (.clk(clk), .rst(rst), .in(din), .out(out_nov));
   seq_detector #(.PAT_LEN(4), .PATTERN(4'b0000), .OVERLAP(1'b1))
      u_z1 (.clk(clk), .rst(rst), .in(din), .out(out_z1));
   seq_detector #(.PAT_LEN(4), .PATTERN(4'b0000), .OVERLAP(1'b0))
      u_z0 (.clk(clk), .rst(rst), .in(din), .out(out_z0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   // e = {def, nov, z1, z0}
   task automatic check_all(input string tag, input logic [3:0] e);
      chk({tag, "_def"}, out_def, e[3]);
      chk({tag, "_nov"}, out_nov, e[2]);
      chk({tag, "_z1"},  out_z1,  e[1]);
      chk({tag, "_z0"},  out_z0,  e[0]);
   endtask

   task automatic step(input logic b, input logic [3:0] e, input string tag);
      @(negedge clk);
      din = b;
      @(posedge clk);
      #1;
      check_all(tag, e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      din = 1'b0;
      rst = 1'b1;
      #1 rst = 1'b0;

      // Held in reset with toggling input
      step(1'b1, 4'b0000, "R1");
      step(1'b0, 4'b0000, "R2");
      step(1'b1, 4'b0000, "R3");
      @(negedge clk);
      rst = 1'b1;

      // Stream 0,0,1,1,0,1,1,0: single hit on bit 6
      step(1'b0, 4'b0000, "A1");
      step(1'b0, 4'b0000, "A2");
      step(1'b1, 4'b0000, "A3");
      step(1'b1, 4'b0000, "A4");
      step(1'b0, 4'b0000, "A5");
      step(1'b1, 4'b1100, "A6");
      step(1'b1, 4'b0000, "A7");
      step(1'b0, 4'b0000, "A8");
      do_reset();

      // Stream 1,1,0,1,1,0,1: overlap hits on 4 and 7, non-overlap only on 4
      step(1'b1, 4'b0000, "B1");
      step(1'b1, 4'b0000, "B2");
      step(1'b0, 4'b0000, "B3");
      step(1'b1, 4'b1100, "B4");
      step(1'b1, 4'b0000, "B5");
      step(1'b0, 4'b0000, "B6");
      step(1'b1, 4'b1000, "B7");
      do_reset();

      // All zeros: startup guard, then every cycle vs every 4th cycle
      step(1'b0, 4'b0000, "C1");
      step(1'b0, 4'b0000, "C2");
      step(1'b0, 4'b0000, "C3");
      step(1'b0, 4'b0011, "C4");
      step(1'b0, 4'b0010, "C5");
      step(1'b0, 4'b0010, "C6");
      step(1'b0, 4'b0010, "C7");
      step(1'b0, 4'b0011, "C8");

      // Asynchronous reset between edges kills the pulse in progress
      #2 rst = 1'b0;
      #1 check_all("ASYNC", 4'b0000);
      @(negedge clk);
      rst = 1'b1;

      // Partial history lost across a mid-sequence reset pulse
      step(1'b1, 4'b0000, "D1");
      step(1'b1, 4'b0000, "D2");
      step(1'b0, 4'b0000, "D3");
      @(negedge clk);
      rst = 1'b0;
      #2 rst = 1'b1;
      step(1'b1, 4'b0000, "D4");
      step(1'b1, 4'b0000, "D5");
      step(1'b1, 4'b0000, "D6");
      step(1'b0, 4'b0000, "D7");
      step(1'b1, 4'b1100, "D8");
      step(1'b0, 4'b0000, "D9");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
